m68k_bus_ctrl: RTL and testbench
================================

Name: m68k_bus_ctrl

Overview:
- Parametrised 68000 bus controller placed between the fx68k core and the memory and peripheral regions (ROM, video RAM, work RAM, SDRAM).
- Decodes the CPU address into N regions and generates DTACKn with per-region wait states and ready back-pressure.
- Raises BERRn on unmapped or timed-out accesses.
- Muxes read data back to the CPU.
- Replaces the fixed "dtack_n always 0" arrangement with the three-way address compare.

Parameters:
NREGIONS, 4, number of decoded regions (1..8)
DEC_HI, 17, top CPU address bit used for decode
DEC_LO, 15, bottom CPU address bit used for decode; region index = cpu_a[DEC_HI:DEC_LO]
WAIT_STATES, 32'h0000_1000, packed 4 bits per region (region r at [4r+3:4r]), minimum clk cycles from latch to ACK; default gives 1 wait to region 3 only
READY_MASK, 8'h00, bit r=1: region r must also assert region_ready[r] before ACK
BERR_TIMEOUT, 64, clk cycles in WAIT before bus error (≥2)

Ports:
clk  in  1  system/CPU clock
reset_n  in  1  asynchronous active-low reset
cpu_as_n  in  1  address strobe
cpu_uds_n  in  1  upper data strobe
cpu_lds_n  in  1  lower data strobe
cpu_rw  in  1  1=read, 0=write
cpu_a  in  23  CPU address [23:1]
region_din  in  16*NREGIONS  read data; region r at [16r+15:16r]
region_ready  in  NREGIONS  per-region ready (used only where READY_MASK bit set)
cpu_din  out  16  read data to CPU
dtack_n  out  1  data transfer acknowledge
berr_n  out  1  bus error
sel  out  NREGIONS  one-hot region select, held for whole access
rd_en  out  1  read access in progress
wr_stb  out  1  single-cycle write strobe
ub  out  1  upper byte enable (latched ~uds_n)
lb  out  1  lower byte enable (latched ~lds_n)

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE
  - dtack_n=1, berr_n=1
  - sel=0, rd_en=0, wr_stb=0, ub=0, lb=0
  - cpu_din=16'h0000
  - counters=0
- States: IDLE, WAIT, ACK, BERR.
- IDLE:
  - Access start = cpu_as_n=0 and (cpu_rw=1 or either data strobe low).
  - On access start, latch region index, rw, ub, lb.
  - Index ≥ NREGIONS → BERR next clk.
  - Otherwise load wait_cnt=WAIT_STATES[r], clear tmo_cnt, set sel[r], set rd_en=cpu_rw, go to WAIT.
- WAIT:
  - wait_cnt decrements to 0 (saturating). tmo_cnt increments each clk.
  - Go-condition: wait_cnt==0 and (READY_MASK[r]=0 or region_ready[r]=1).
  - On go-condition → ACK. Assert dtack_n=0 on entry.
  - Read: cpu_din captures region_din[r] in the same clk as dtack_n falls.
  - Write: wr_stb=1 for exactly that one clk.
  - Zero wait states → ACK on the 2nd clk after AS is sampled low.
- ACK:
  - Hold dtack_n=0 and cpu_din stable until cpu_as_n=1.
  - Then → IDLE. dtack_n=1, sel=0, rd_en=0, ub=lb=0 on that edge.
- BERR:
  - From WAIT when tmo_cnt reaches BERR_TIMEOUT and go-condition is false (go-condition wins a tie), or from IDLE when unmapped.
  - berr_n=0, dtack_n stays 1, no wr_stb.
  - Hold until cpu_as_n=1, then IDLE with berr_n=1.
- Abort: cpu_as_n=1 while in WAIT → IDLE next clk. No dtack, no wr_stb, sel cleared.
- Back-to-back: a new access is only recognised in IDLE. AS must be seen high at least one clk between accesses.
- Read-modify-write (TAS): AS stays low across read and write. Strobes rising then falling again with AS held low starts a new access via IDLE only after AS negates. TAS targets are unsupported and documented as such.
- Strobe latching: ub/lb are latched at access start and are not re-sampled.
- Address: cpu_a bits outside DEC_HI:DEC_LO are ignored here; regions use them directly.
- Reset mid-access: all outputs return to reset values immediately (asynchronous).

Test Plan:
- Read region 0, WAIT_STATES r0=0, region_din r0=16'h4E71 → dtack_n low 2 clk after AS low, cpu_din=16'h4E71, sel=4'b0001, wr_stb never high.
- Write region 3 (a[17:15]=3) with r3 wait=1, uds_n=0, lds_n=1 → sel=4'b1000, ub=1, lb=0, wr_stb high exactly 1 clk coincident with dtack_n falling 3 clk after AS; dtack_n released the clk after AS negates.
- READY_MASK bit1=1, region_ready[1] held low 10 clk then high → dtack_n falls the clk after ready rises; no berr.
- region_ready[1] held low with BERR_TIMEOUT=64 → berr_n low after 64 WAIT clk, dtack_n stays 1; berr_n returns 1 after AS negates.
- a[17:15]=5 with NREGIONS=4 → berr_n low next clk, sel=0. Separately, AS negated after 1 clk in WAIT → IDLE, no dtack, no wr_stb.
- reset_n pulsed low during ACK → dtack_n=1, sel=0 with no clock edge; next access completes normally.

Source files
------------

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: decodes the CPU address into regions, generates DTACKn
// after per-region wait states / ready, raises BERRn on unmapped or stalled accesses.
module m68k_bus_ctrl #(
   parameter int          NREGIONS     = 4,
   parameter int          DEC_HI       = 17,
   parameter int          DEC_LO       = 15,
   parameter logic [31:0] WAIT_STATES  = 32'h0000_1000,
   parameter logic [7:0]  READY_MASK   = 8'h00,
   parameter int          BERR_TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cpu_as_n,
   input  logic                     cpu_uds_n,
   input  logic                     cpu_lds_n,
   input  logic                     cpu_rw,
   input  logic [23:1]              cpu_a,
   input  logic [16*NREGIONS-1:0]   region_din,
   input  logic [NREGIONS-1:0]      region_ready,
   output logic [15:0]              cpu_din,
   output logic                     dtack_n,
   output logic                     berr_n,
   output logic [NREGIONS-1:0]      sel,
   output logic                     rd_en,
   output logic                     wr_stb,
   output logic                     ub,
   output logic                     lb
);

   localparam int IW = DEC_HI - DEC_LO + 1;
   localparam int TW = $clog2(BERR_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;

   state_t                state, state_d;
   logic [IW-1:0]         idx_q, idx_d, idx_in;
   logic                  rw_q, rw_d;
   logic [3:0]            wait_cnt, wait_cnt_d, wait_ld;
   logic [TW-1:0]         tmo_cnt, tmo_cnt_d, tmo_inc;
   logic [15:0]           cpu_din_d, rdata;
   logic                  dtack_n_d, berr_n_d, rd_en_d, wr_stb_d, ub_d, lb_d;
   logic [NREGIONS-1:0]   sel_d, sel_ld;
   logic                  rdy_ok, go, start;

   // Only the decode field is used here; the regions consume the rest of the address.
   logic unused_addr;
   assign unused_addr = ^cpu_a;

   always_comb begin
      idx_in  = cpu_a[DEC_HI:DEC_LO];
      wait_ld = 4'd0;
      sel_ld  = '0;
      rdata   = 16'h0000;
      rdy_ok  = 1'b0;
      for (int r = 0; r < NREGIONS; r++) begin
         if (idx_in == IW'(r)) begin
            wait_ld   = WAIT_STATES[4*r +: 4];
            sel_ld[r] = 1'b1;
         end
         if (idx_q == IW'(r)) begin
            rdata  = region_din[16*r +: 16];
            rdy_ok = !READY_MASK[r] || region_ready[r];
         end
      end
      go      = (wait_cnt == 4'd0) && rdy_ok;
      tmo_inc = tmo_cnt + TW'(1);
      start   = !cpu_as_n && (cpu_rw || !cpu_uds_n || !cpu_lds_n);
   end

   always_comb begin
      state_d    = state;
      idx_d      = idx_q;
      rw_d       = rw_q;
      wait_cnt_d = wait_cnt;
      tmo_cnt_d  = tmo_cnt;
      cpu_din_d  = cpu_din;
      dtack_n_d  = dtack_n;
      berr_n_d   = berr_n;
      sel_d      = sel;
      rd_en_d    = rd_en;
      wr_stb_d   = 1'b0;
      ub_d       = ub;
      lb_d       = lb;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               idx_d = idx_in;
               rw_d  = cpu_rw;
               ub_d  = !cpu_uds_n;
               lb_d  = !cpu_lds_n;
               // No region matched the index: unmapped access.
               if (sel_ld == '0) begin
                  state_d  = S_BERR;
                  berr_n_d = 1'b0;
               end else begin
                  state_d    = S_WAIT;
                  wait_cnt_d = wait_ld;
                  tmo_cnt_d  = '0;
                  sel_d      = sel_ld;
                  rd_en_d    = cpu_rw;
               end
            end
         end
         S_WAIT: begin
            if (cpu_as_n) begin
               state_d = S_IDLE;
               sel_d   = '0;
               rd_en_d = 1'b0;
               ub_d    = 1'b0;
               lb_d    = 1'b0;
            end else if (go) begin
               state_d   = S_ACK;
               dtack_n_d = 1'b0;
               if (rw_q) cpu_din_d = rdata;
               else      wr_stb_d  = 1'b1;
            end else begin
               wait_cnt_d = (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
               tmo_cnt_d  = tmo_inc;
               if (tmo_inc == TW'(BERR_TIMEOUT)) begin
                  state_d  = S_BERR;
                  berr_n_d = 1'b0;
               end
            end
         end
         S_ACK, S_BERR: begin
            if (cpu_as_n) begin
               state_d   = S_IDLE;
               dtack_n_d = 1'b1;
               berr_n_d  = 1'b1;
               sel_d     = '0;
               rd_en_d   = 1'b0;
               ub_d      = 1'b0;
               lb_d      = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         idx_q    <= '0;
         rw_q     <= 1'b0;
         wait_cnt <= 4'd0;
         tmo_cnt  <= '0;
         cpu_din  <= 16'h0000;
         dtack_n  <= 1'b1;
         berr_n   <= 1'b1;
         sel      <= '0;
         rd_en    <= 1'b0;
         wr_stb   <= 1'b0;
         ub       <= 1'b0;
         lb       <= 1'b0;
      end else begin
         state    <= state_d;
         idx_q    <= idx_d;
         rw_q     <= rw_d;
         wait_cnt <= wait_cnt_d;
         tmo_cnt  <= tmo_cnt_d;
         cpu_din  <= cpu_din_d;
         dtack_n  <= dtack_n_d;
         berr_n   <= berr_n_d;
         sel      <= sel_d;
         rd_en    <= rd_en_d;
         wr_stb   <= wr_stb_d;
         ub       <= ub_d;
         lb       <= lb_d;
      end
   end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: expected access outcomes are queued when an
// access is driven and compared when DTACKn or BERRn responds.
module tb_m68k_bus_ctrl;

   localparam logic [31:0] WS  = 32'h0000_1000;
   localparam logic [7:0]  RM  = 8'h02;
   localparam int          TMO = 64;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
   logic [23:1] cpu_a;
   logic [63:0] region_din;
   logic [3:0]  region_ready;
   logic [15:0] cpu_din;
   logic        dtack_n, berr_n, rd_en, wr_stb, ub, lb;
   logic [3:0]  sel;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          lat;
      logic        berr;
      logic [15:0] din;
      logic [3:0]  sel;
      logic        rw;
      logic        ub;
      logic        lb;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] din_tbl [4] = '{16'h4E71, 16'h1111, 16'h2222, 16'hABCD};

   m68k_bus_ctrl #(
      .NREGIONS(4), .DEC_HI(17), .DEC_LO(15),
      .WAIT_STATES(WS), .READY_MASK(RM), .BERR_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n),
      .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_a(cpu_a),
      .region_din(region_din), .region_ready(region_ready), .cpu_din(cpu_din),
      .dtack_n(dtack_n), .berr_n(berr_n), .sel(sel), .rd_en(rd_en),
      .wr_stb(wr_stb), .ub(ub), .lb(lb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Edge count (edge 1 samples AS low) at which DTACKn or BERRn should fall.
   function automatic exp_t model(input int idx, input logic rw, input logic uds_n,
                                  input logic lds_n, input int rdy_at);
      exp_t e;
      int   go;
      e.rw  = rw;
      e.ub  = !uds_n;
      e.lb  = !lds_n;
      e.din = 16'h0000;
      if (idx >= 4) begin
         e.berr = 1'b1;
         e.lat  = 1;
         e.sel  = 4'b0000;
      end else begin
         e.din = din_tbl[idx];
         e.sel = 4'(1 << idx);
         go    = 2 + int'((WS >> (4*idx)) & 32'hF);
         if (RM[idx]) begin
            if (rdy_at == 0)          go = 100000;
            else if (rdy_at + 1 > go) go = rdy_at + 1;
         end
         if (go <= TMO + 1) begin
            e.berr = 1'b0;
            e.lat  = go;
         end else begin
            e.berr = 1'b1;
            e.lat  = TMO + 1;
         end
      end
      return e;
   endfunction

   task automatic release_bus();
      @(negedge clk);
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      @(posedge clk); #1;
      check("rel_dtack_n", dtack_n, 1'b1);
      check("rel_berr_n", berr_n, 1'b1);
      check("rel_sel", sel, 4'b0000);
      check("rel_ub_lb", {rd_en, ub, lb}, 3'b000);
   endtask

   task automatic access(input int idx, input logic rw, input logic uds_n,
                         input logic lds_n, input int rdy_at, input bit hold);
      exp_t e;
      int   n, wr_cnt;
      logic wr_at;
      sb.push_back(model(idx, rw, uds_n, lds_n, rdy_at));
      @(negedge clk);
      cpu_a          = '0;
      cpu_a[17:15]   = 3'(idx);
      cpu_rw         = rw;
      cpu_uds_n      = uds_n;
      cpu_lds_n      = lds_n;
      cpu_as_n       = 1'b0;
      region_ready   = 4'b1101;
      n      = 0;
      wr_cnt = 0;
      while (n < 200) begin
         @(posedge clk); #1;
         n++;
         if (wr_stb) wr_cnt++;
         if (!dtack_n || !berr_n) break;
         if (n == rdy_at) region_ready[1] = 1'b1;
      end
      wr_at = wr_stb;
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("berr_n", berr_n, !e.berr);
      check("dtack_n", dtack_n, e.berr);
      check("sel", sel, e.sel);
      check("ub_lb", {ub, lb}, {e.ub, e.lb});
      if (!e.berr) check("rd_en", rd_en, e.rw);
      if (!e.berr && e.rw) check("cpu_din", cpu_din, e.din);
      if (!e.berr && !e.rw) check("wr_stb_at_dtack", wr_at, 1'b1);
      @(posedge clk); #1;
      if (wr_stb) wr_cnt++;
      check("resp_held", {dtack_n, berr_n}, {e.berr, !e.berr});
      if (!e.berr && e.rw) check("cpu_din_held", cpu_din, e.din);
      check("wr_stb_count", wr_cnt, (!e.berr && !e.rw) ? 1 : 0);
      if (!hold) release_bus();
   endtask

   initial begin
      int dt_seen, wr_seen;
      reset_n      = 1'b0;
      cpu_as_n     = 1'b1;
      cpu_uds_n    = 1'b1;
      cpu_lds_n    = 1'b1;
      cpu_rw       = 1'b1;
      cpu_a        = '0;
      region_ready = 4'b1101;
      region_din   = {din_tbl[3], din_tbl[2], din_tbl[1], din_tbl[0]};
      repeat (3) @(posedge clk);
      #1;
      check("rst_dtack_berr", {dtack_n, berr_n}, 2'b11);
      check("rst_sel", sel, 4'b0000);
      check("rst_ctl", {rd_en, wr_stb, ub, lb}, 4'b0000);
      check("rst_cpu_din", cpu_din, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      access(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);   // zero-wait read
      access(3, 1'b0, 1'b0, 1'b1, 0, 1'b0);   // one-wait upper-byte write
      access(2, 1'b1, 1'b1, 1'b0, 0, 1'b0);   // lower-byte read
      access(1, 1'b1, 1'b0, 1'b0, 10, 1'b0);  // ready-gated read
      access(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);   // ready never rises: timeout
      access(5, 1'b1, 1'b0, 1'b0, 0, 1'b0);   // unmapped
      access(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);   // lower-byte write

      // Abort: AS negated after one clock in WAIT.
      @(negedge clk);
      cpu_a        = '0;
      cpu_a[17:15] = 3'd3;
      cpu_rw       = 1'b0;
      cpu_uds_n    = 1'b0;
      cpu_lds_n    = 1'b0;
      cpu_as_n     = 1'b0;
      dt_seen = 0;
      wr_seen = 0;
      @(posedge clk); #1;
      check("abort_sel_wait", sel, 4'b1000);
      @(posedge clk); #1;
      @(negedge clk);
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (!dtack_n) dt_seen++;
         if (wr_stb)   wr_seen++;
      end
      check("abort_no_dtack", dt_seen, 0);
      check("abort_no_wr_stb", wr_seen, 0);
      check("abort_sel", sel, 4'b0000);
      access(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

      // Asynchronous reset while in ACK.
      access(3, 1'b1, 1'b0, 1'b0, 0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_dtack_n", dtack_n, 1'b1);
      check("arst_sel", sel, 4'b0000);
      check("arst_cpu_din", cpu_din, 16'h0000);
      @(negedge clk);
      reset_n   = 1'b1;
      cpu_as_n  = 1'b1;
      cpu_uds_n = 1'b1;
      cpu_lds_n = 1'b1;
      @(negedge clk);
      access(3, 1'b1, 1'b0, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
